// File: rtl/ci_dispatch_pkg.sv
// rtl/ci_dispatch_pkg.sv - shared types and constants for the custom-instruction dispatcher
package ci_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESPOND
    } state_t;

    localparam int          N_UNITS      = 4;
    localparam logic [31:0] TIMEOUT_WORD = 32'hDEADBEEF;

    localparam int STAT_TO_LSB   = 0;
    localparam int STAT_TO_W     = 8;
    localparam int STAT_DONE_LSB = 8;
    localparam int STAT_DONE_W   = 16;
    localparam int STAT_LAST_LSB = 24;
    localparam int STAT_LAST_W   = 4;

    function automatic logic [31:0] status_word(
        input logic [STAT_TO_W-1:0]   to_cnt,
        input logic [STAT_DONE_W-1:0] done_cnt,
        input logic [STAT_LAST_W-1:0] last_unit
    );
        logic [31:0] w;
        w = '0;
        w[STAT_TO_LSB   +: STAT_TO_W]   = to_cnt;
        w[STAT_DONE_LSB +: STAT_DONE_W] = done_cnt;
        w[STAT_LAST_LSB +: STAT_LAST_W] = last_unit;
        return w;
    endfunction

endpackage

// File: rtl/ci_dispatcher_sat_counter.sv
// rtl/ci_dispatcher_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/ci_dispatcher.sv
// rtl/ci_dispatcher.sv - routes CPU custom instructions to four units and returns their results
module ci_dispatcher
    import ci_dispatch_pkg::*;
#(
    parameter logic [7:0] ID0       = 8'd8,
    parameter logic [7:0] ID1       = 8'd9,
    parameter logic [7:0] ID2       = 8'd10,
    parameter logic [7:0] ID3       = 8'd11,
    parameter logic [7:0] STATUS_ID = 8'hFF,
    parameter int         TIMEOUT   = 255
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   ciN,
    input  logic [31:0]  valueA,
    input  logic [31:0]  valueB,
    output logic         done,
    output logic [31:0]  result,
    output logic [3:0]   unitStart,
    output logic [31:0]  unitValueA,
    output logic [31:0]  unitValueB,
    input  logic [3:0]   unitDone,
    input  logic [127:0] unitResult,
    output logic         busy,
    output logic         timeoutErr
);

    localparam logic [7:0]  UNIT_IDS [N_UNITS] = '{ID0, ID1, ID2, ID3};
    localparam logic [15:0] TO_LIMIT = TIMEOUT[15:0];

    state_t      state_q, state_d;
    logic [1:0]  sel_q;
    logic [31:0] a_q, b_q, res_q, res_d;
    logic [15:0] wcnt_q;
    logic [3:0]  last_q;
    logic [7:0]  to_cnt;
    logic [15:0] done_cnt;
    logic        hit, inc_to, inc_done;
    logic [1:0]  hit_idx;
    logic        sel_done;
    logic [31:0] sel_res;

    // Scan downward so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 2'd0;
        for (int k = N_UNITS - 1; k >= 0; k--) begin
            if (ciN == UNIT_IDS[k]) begin
                hit     = 1'b1;
                hit_idx = 2'(k);
            end
        end
    end

    assign sel_done = unitDone[sel_q];
    assign sel_res  = unitResult[{sel_q, 5'd0} +: 32];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        inc_to   = 1'b0;
        inc_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (hit) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_RESPOND;
                        res_d   = (ciN == STATUS_ID) ? status_word(to_cnt, done_cnt, last_q) : '0;
                    end
                end
            end
            ST_ISSUE: begin
                if (sel_done) begin
                    res_d    = sel_res;
                    inc_done = 1'b1;
                    state_d  = ST_RESPOND;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A unit answer in the timeout cycle beats the timeout.
                if (sel_done) begin
                    res_d    = sel_res;
                    inc_done = 1'b1;
                    state_d  = ST_RESPOND;
                end else if (wcnt_q == TO_LIMIT) begin
                    res_d   = TIMEOUT_WORD;
                    inc_to  = 1'b1;
                    state_d = ST_RESPOND;
                end
            end
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sel_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            wcnt_q <= '0;
            last_q <= '0;
        end else begin
            res_q <= res_d;
            if (state_q == ST_IDLE && start) begin
                sel_q <= hit_idx;
                a_q   <= valueA;
                b_q   <= valueB;
            end
            if (state_q == ST_ISSUE)     wcnt_q <= 16'd1;
            else if (state_q == ST_WAIT) wcnt_q <= wcnt_q + 16'd1;
            if (inc_done) last_q <= 4'b0001 << sel_q;
        end
    end

    sat_counter #(.W(STAT_TO_W)) u_to_cnt (
        .clock (clock),
        .reset (reset),
        .clear (1'b0),
        .inc   (inc_to),
        .count (to_cnt)
    );

    sat_counter #(.W(STAT_DONE_W)) u_done_cnt (
        .clock (clock),
        .reset (reset),
        .clear (1'b0),
        .inc   (inc_done),
        .count (done_cnt)
    );

    assign done       = (state_q == ST_RESPOND);
    assign result     = done ? res_q : '0;
    assign busy       = (state_q != ST_IDLE);
    assign unitStart  = (state_q == ST_ISSUE) ? (4'b0001 << sel_q) : 4'b0000;
    assign unitValueA = a_q;
    assign unitValueB = b_q;
    assign timeoutErr = inc_to;

endmodule

// File: doc/ci_dispatcher.md
CI_DISPATCHER -- requirements
Module: ci_dispatcher

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- ID0  8'd8  customId of unit 0
- ID1  8'd9  customId of unit 1
- ID2  8'd10  customId of unit 2
- ID3  8'd11  customId of unit 3
- STATUS_ID  8'hFF  customId that reads the dispatcher status word
- TIMEOUT  255  maximum WAIT cycles (1..65535)
REQ-002 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clock  input  1  rising-edge clock
- reset  input  1  reset, asynchronous, active-low
- start  input  1  CPU custom-instruction request
- ciN  input  8  requested customId
- valueA  input  32  operand A
- valueB  input  32  operand B
- done  output  1  one-cycle completion pulse to CPU
- result  output  32  result; 0 whenever done=0
- unitStart  output  4  one-hot start to units 0..3
- unitValueA  output  32  latched operand A to units
- unitValueB  output  32  latched operand B to units
- unitDone  input  4  per-unit done
- unitResult  input  128  unit k result on bits [32k+31:32k]
- busy  output  1  high in every state except IDLE
- timeoutErr  output  1  one-cycle pulse on timeout

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT, RESPOND.
REQ-004 In IDLE, start=1 SHALL latch ciN, valueA and valueB.
- ciN matches a unit ID: go to ISSUE.
- ciN==STATUS_ID and no unit matches: go to RESPOND with the status word.
- Otherwise: go to RESPOND with result 0.
REQ-005 If several IDs are equal, the lowest unit index SHALL win.
REQ-006 While busy=1, start SHALL be ignored, and the latched operands SHALL NOT change.
REQ-007 ISSUE SHALL last exactly one cycle, with unitStart[k]=1 only for the selected unit k.
REQ-008 unitValueA and unitValueB SHALL hold the latched operands in ISSUE and WAIT.
REQ-009 In ISSUE, unitDone[k]=1 SHALL capture unitResult[k] and go to RESPOND; otherwise the FSM SHALL go to WAIT.
REQ-010 In WAIT, a cycle counter SHALL start at 1 and increment each cycle.
- unitDone[k]=1: capture unitResult[k] and go to RESPOND.
- Else, counter==TIMEOUT: capture 32'hDEADBEEF, pulse timeoutErr, and go to RESPOND.
REQ-011 If unitDone[k] and the timeout occur in the same cycle, the unit result SHALL win and no timeout SHALL be counted.
REQ-012 unitDone from non-selected units, and any unitDone seen in IDLE or RESPOND, SHALL be ignored.
REQ-013 RESPOND SHALL drive done=1 with the captured result for exactly one cycle, then return to IDLE.
- A new start is accepted from the next cycle on.
REQ-014 Latency from the start cycle to done SHALL be:
- 1 cycle for unknown or status requests;
- 2 cycles for a single-cycle unit;
- n+2 cycles for a unit that raises done n cycles after unitStart.
REQ-015 The status word SHALL have these fields:
- [7:0] timeout count, saturating at 255;
- [23:8] completed unit transactions, saturating at 65535;
- [27:24] one-hot index of the last unit served;
- [31:28] 0.
REQ-016 Status and unknown-ID requests SHALL NOT change any counter; a timeout SHALL NOT increment the completed count.

Reset
REQ-017 reset=0 SHALL immediately force all of the following, including mid-transaction, where the pending request is dropped:
- FSM to IDLE;
- done, busy, timeoutErr and unitStart to 0;
- result, unitValueA and unitValueB to 0;
- WAIT counter, timeout count, completed count and last-unit field to 0.
REQ-018 After reset deasserts, the first accepted start SHALL behave as from IDLE.

Structure
REQ-019 A shared package ci_dispatch_pkg SHALL hold:
- the state enum;
- the 32'hDEADBEEF timeout constant;
- the status field bit positions;
- the unit count (4).
REQ-020 The timeout and completed counters SHALL be instances of one sub-module, sat_counter, parameterised by width, with clear and increment inputs.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Unknown ID: ciN=8'h11, start=1 -> done=1 one cycle later, result=0, unitStart never asserted.
- Single-cycle unit: ciN=8'd8, valueA=5, unit0 returns done and 32'h1234 with its start -> unitStart=4'b0001 for one cycle, done two cycles after start, result=32'h1234.
- Multi-cycle unit: ciN=8'd10, unit2 raises done 3 cycles after its start with 32'hA5A5A5A5 -> done at cycle 5, result=32'hA5A5A5A5; a start at cycle 2 is ignored.
- Timeout: TIMEOUT=4, unit1 never raises done -> timeoutErr pulse, done with 32'hDEADBEEF; a following status read returns [7:0]=1.
- Status: after two completed unit0 transactions, ciN=8'hFF -> result=32'h0100_0200.
- Reset mid-WAIT: reset=0 -> busy=0 and unitStart=0 immediately; a status read after release returns 0.
